// File: rtl/td4_run_ctrl_if.sv
// Control/status bundle between board controls, the TD4 core REGS stage and td4_run_ctrl.
// master = board/core side, slave = the run controller.
interface td4_run_ctrl_if;
  logic        start_i;
  logic        stop_i;
  logic        step_i;
  logic        brk_en_i;
  logic [3:0]  brk_ip_i;
  logic [3:0]  cur_ip_i;
  logic        exec_en_o;
  logic [1:0]  state_o;
  logic        halted_o;
  logic [15:0] insn_cnt_o;

  modport master (
    output start_i, stop_i, step_i, brk_en_i, brk_ip_i, cur_ip_i,
    input  exec_en_o, state_o, halted_o, insn_cnt_o
  );

  modport slave (
    input  start_i, stop_i, step_i, brk_en_i, brk_ip_i, cur_ip_i,
    output exec_en_o, state_o, halted_o, insn_cnt_o
  );
endinterface

// File: rtl/td4_run_ctrl.sv
// Run/halt/single-step sequencer producing the TD4 core's one-cycle execute enable.
// Optional instruction counter: define TD4_RUN_CTRL_INSN_CNT_EN.
module td4_run_ctrl #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  td4_run_ctrl_if.slave bus
);

  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  logic [1:0]       state_q, state_d;
  logic             exec_q, exec_d;
  logic             halted_q, halted_d;
  logic             first_q, first_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             wrap;
  logic             brk_hit;

  assign wrap    = (presc_q == PRESC_LAST);
  // The first exec after a start is exempt so a breakpointed instruction can be resumed.
  assign brk_hit = bus.brk_en_i && (bus.cur_ip_i == bus.brk_ip_i) && !first_q;

  always_comb begin
    state_d = state_q;
    exec_d  = 1'b0;
    first_d = first_q;
    presc_d = presc_q;
    case (state_q)
      ST_HALT, ST_BREAK: begin
        if (bus.start_i) begin
          state_d = ST_RUN;
          presc_d = '0;
          first_d = 1'b1;
        end else if (bus.step_i) begin
          state_d = ST_STEP;
        end else if (bus.stop_i && (state_q == ST_BREAK)) begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        presc_d = wrap ? '0 : presc_q + DIV_W'(1);
        if (bus.stop_i) begin
          state_d = ST_HALT;
        end else if (wrap) begin
          if (brk_hit) begin
            state_d = ST_BREAK;
          end else begin
            exec_d  = 1'b1;
            first_d = 1'b0;
          end
        end
      end
      ST_STEP: begin
        // Two-cycle visit: pulse on the first cycle, return to HALT on the second.
        if (exec_q) state_d = ST_HALT;
        else        exec_d  = 1'b1;
      end
      default: state_d = ST_HALT;
    endcase
    halted_d = (state_d == ST_HALT) || (state_d == ST_BREAK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HALT;
      exec_q   <= 1'b0;
      halted_q <= 1'b1;
      first_q  <= 1'b0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      exec_q   <= exec_d;
      halted_q <= halted_d;
      first_q  <= first_d;
      presc_q  <= presc_d;
    end
  end

  assign bus.exec_en_o = exec_q;
  assign bus.state_o   = state_q;
  assign bus.halted_o  = halted_q;

`ifdef TD4_RUN_CTRL_INSN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + {15'd0, exec_q};

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.insn_cnt_o = cnt_q;
`else
  assign bus.insn_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl: one DIV=4 instance for sequencing, one DIV=1 for the counter.
module tb_td4_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef TD4_RUN_CTRL_INSN_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  td4_run_ctrl_if b4 ();
  td4_run_ctrl_if b1 ();

  td4_run_ctrl #(.DIV(4), .DIV_W(16)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  td4_run_ctrl #(.DIV(1), .DIV_W(16)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk4(input string name, input logic exp_en, input logic [1:0] exp_st);
    n_tests++;
    if (b4.exec_en_o !== exp_en || b4.state_o !== exp_st) begin
      n_fail++;
      $display("FAIL %s: exec_en=%b state=%0d, expected exec_en=%b state=%0d",
               name, b4.exec_en_o, b4.state_o, exp_en, exp_st);
    end
  endtask

  task automatic start4();
    b4.start_i = 1'b1; cyc(1); b4.start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
    chk4("reset_state", 1'b0, 2'd0);
    n_tests++;
    if (b4.halted_o !== 1'b1 || b4.insn_cnt_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_flags: halted=%b cnt=%h, expected halted=1 cnt=0000", b4.halted_o, b4.insn_cnt_o);
    end
  endtask

  task automatic test_run();
    logic [15:0] exp_cnt;
    cyc(5);
    start4();
    chk4("run_enter", 1'b0, 2'd1);
    n_tests++;
    if (b4.halted_o !== 1'b0) begin
      n_fail++;
      $display("FAIL run_halted: got %b, expected 0", b4.halted_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(3); chk4("run_gap", 1'b0, 2'd1);
      cyc(1); chk4("run_pulse", 1'b1, 2'd1);
    end
    b4.stop_i = 1'b1; cyc(1); b4.stop_i = 1'b0;
    chk4("run_stop", 1'b0, 2'd0);
    exp_cnt = CNT_ON ? 16'd3 : 16'd0;
    n_tests++;
    if (b4.insn_cnt_o !== exp_cnt || b4.halted_o !== 1'b1) begin
      n_fail++;
      $display("FAIL run_cnt: cnt=%0d halted=%b, expected cnt=%0d halted=1", b4.insn_cnt_o, b4.halted_o, exp_cnt);
    end
    b4.stop_i = 1'b1; cyc(1); b4.stop_i = 1'b0;
    chk4("halt_stop_ignored", 1'b0, 2'd0);
  endtask

  task automatic test_step();
    b4.step_i = 1'b1; cyc(1);
    chk4("step_enter", 1'b0, 2'd2);
    // step held into the STEP cycle must not retrigger
    cyc(1); b4.step_i = 1'b0;
    chk4("step_pulse", 1'b1, 2'd2);
    cyc(1);
    chk4("step_done", 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1); chk4("step_quiet", 1'b0, 2'd0);
    end
  endtask

  task automatic test_breakpoint();
    logic [3:0] ip;
    ip = 4'h0;
    b4.cur_ip_i = ip; b4.brk_ip_i = 4'h3; b4.brk_en_i = 1'b1;
    start4();
    for (int i = 0; i < 3; i++) begin
      cyc(3); chk4("brk_gap", 1'b0, 2'd1);
      cyc(1); chk4("brk_pre_pulse", 1'b1, 2'd1);
      ip = ip + 4'h1; b4.cur_ip_i = ip;
    end
    cyc(3); chk4("brk_gap4", 1'b0, 2'd1);
    cyc(1); chk4("brk_hit", 1'b0, 2'd3);
    n_tests++;
    if (b4.halted_o !== 1'b1) begin
      n_fail++;
      $display("FAIL brk_halted: got %b, expected 1", b4.halted_o);
    end
    start4();
    chk4("brk_resume", 1'b0, 2'd1);
    cyc(4); chk4("brk_resume_exec_ip3", 1'b1, 2'd1);
    ip = ip + 4'h1; b4.cur_ip_i = ip;
    for (int i = 0; i < 15; i++) begin
      cyc(4); chk4("brk_loop_pulse", 1'b1, 2'd1);
      ip = ip + 4'h1; b4.cur_ip_i = ip;
    end
    cyc(4); chk4("brk_hit_again", 1'b0, 2'd3);
    b4.stop_i = 1'b1; cyc(1); b4.stop_i = 1'b0;
    chk4("brk_stop_to_halt", 1'b0, 2'd0);
    b4.brk_en_i = 1'b0;
  endtask

  task automatic test_stop_on_wrap();
    start4();
    cyc(3);
    b4.stop_i = 1'b1; cyc(1); b4.stop_i = 1'b0;
    chk4("stop_wrap", 1'b0, 2'd0);
    b4.cur_ip_i = 4'h5; b4.brk_ip_i = 4'h5; b4.brk_en_i = 1'b1;
    start4();
    cyc(4); chk4("stop_brk_first_exec", 1'b1, 2'd1);
    cyc(3);
    b4.stop_i = 1'b1; cyc(1); b4.stop_i = 1'b0;
    chk4("stop_brk_wrap", 1'b0, 2'd0);
    b4.brk_en_i = 1'b0;
  endtask

  task automatic test_start_step_rst();
    b4.start_i = 1'b1; b4.step_i = 1'b1; cyc(1);
    b4.start_i = 1'b0; b4.step_i = 1'b0;
    chk4("start_wins", 1'b0, 2'd1);
    cyc(4); chk4("start_wins_pulse", 1'b1, 2'd1);
    cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk4("rst_midrun", 1'b0, 2'd0);
    n_tests++;
    if (b4.halted_o !== 1'b1 || b4.insn_cnt_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_midrun_flags: halted=%b cnt=%h, expected halted=1 cnt=0000", b4.halted_o, b4.insn_cnt_o);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1); chk4("rst_no_stray", 1'b0, 2'd0);
    end
  endtask

  task automatic test_insn_cnt();
    int          pulses;
    logic [15:0] exp_cnt;
    pulses = 0;
    b1.start_i = 1'b1; cyc(1); b1.start_i = 1'b0;
    repeat (70000) begin
      cyc(1);
      if (b1.exec_en_o === 1'b1) pulses++;
    end
    b1.stop_i = 1'b1; cyc(1); b1.stop_i = 1'b0;
    n_tests++;
    if (pulses != 70000 || b1.state_o !== 2'd0 || b1.exec_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL div1_pulses: pulses=%0d state=%0d exec_en=%b, expected 70000 0 0", pulses, b1.state_o, b1.exec_en_o);
    end
    exp_cnt = CNT_ON ? 16'(pulses) : 16'h0000;
    n_tests++;
    if (b1.insn_cnt_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL insn_cnt_wrap: got %0d, expected %0d", b1.insn_cnt_o, exp_cnt);
    end
    cyc(3);
    n_tests++;
    if (b1.insn_cnt_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL insn_cnt_hold: got %0d, expected %0d", b1.insn_cnt_o, exp_cnt);
    end
  endtask

  initial begin
    b4.start_i = 1'b0; b4.stop_i = 1'b0; b4.step_i = 1'b0;
    b4.brk_en_i = 1'b0; b4.brk_ip_i = 4'h0; b4.cur_ip_i = 4'h0;
    b1.start_i = 1'b0; b1.stop_i = 1'b0; b1.step_i = 1'b0;
    b1.brk_en_i = 1'b0; b1.brk_ip_i = 4'h0; b1.cur_ip_i = 4'h0;
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_stop_on_wrap();
    test_start_step_rst();
    test_insn_cnt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/td4_run_ctrl.md
Name: td4_run_ctrl

Overview:
Run/halt/single-step sequencer for the 4-bit TD4-style core.
- Generates the one-cycle execute enable that gates the core's REGS update (a, b, ip, cf, out).
- Provides free-run at a divided rate, single-step, stop, and one hardware breakpoint on ip.
- Sits between the board's control buttons/switches and the core register stage.

Parameters:
DIV, 4, clocks per executed instruction in RUN; legal range 1..65535.
DIV_W, 16, prescaler width; must satisfy DIV <= 2**DIV_W.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start_i  input  1  single-cycle pulse: enter RUN
stop_i  input  1  single-cycle pulse: enter HALT
step_i  input  1  single-cycle pulse: execute exactly one instruction
brk_en_i  input  1  breakpoint enable (level)
brk_ip_i  input  4  breakpoint address
cur_ip_i  input  4  current ip from core REGS (stable between exec_en pulses)
exec_en_o  output  1  registered; high one cycle = core commits one instruction at the next edge
state_o  output  2  0=HALT, 1=RUN, 2=STEP, 3=BREAK
halted_o  output  1  high when state is HALT or BREAK
insn_cnt_o  output  16  executed-instruction count (see Optional Feature)

Behaviour:
- Reset: state HALT, exec_en_o 0, prescaler 0, first-exec flag 0, insn_cnt_o 0. rst during RUN/STEP aborts; no exec_en_o after the reset edge.
- All outputs are registered; no combinational input-to-output path.
- HALT/BREAK:
  - start_i -> RUN; prescaler cleared; first-exec flag set.
  - step_i -> STEP.
  - start_i and step_i together: start wins.
  - In BREAK, stop_i -> HALT. In HALT, stop_i is ignored.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - On the edge where it wraps, exec_en_o is set for one cycle.
  - For start sampled at edge k, exec_en_o is high after edges k+DIV, k+2*DIV, and so on.
  - DIV=1 gives exec_en_o high every cycle.
- Breakpoint:
  - At an edge that would set exec_en_o in RUN: if brk_en_i=1, cur_ip_i==brk_ip_i and the first-exec flag is 0, exec_en_o stays 0 and state -> BREAK.
  - The first-exec flag clears on the first exec_en_o after start, so resuming from a breakpoint executes the breakpointed instruction.
- stop_i in RUN:
  - -> HALT at that edge; any exec_en_o that edge would have set is suppressed.
  - stop_i with a coinciding breakpoint -> HALT, not BREAK.
- step_i in RUN: ignored.
- STEP:
  - For step sampled at edge k: state STEP and exec_en_o high after edge k+1.
  - After edge k+2: state HALT, exec_en_o 0.
  - Breakpoint is ignored in STEP. start_i/stop_i/step_i are ignored while in STEP.
- exec_en_o is never high for two consecutive cycles unless DIV=1 in RUN.
- Prescaler holds its value outside RUN.
- halted_o = (state==HALT) | (state==BREAK); updated in the same edge as state_o.

Optional Feature:
Macro TD4_RUN_CTRL_INSN_CNT_EN.
- Defined:
  - insn_cnt_o is a 16-bit counter incremented on every cycle exec_en_o is high; wraps 16'hFFFF -> 0.
  - Cleared only by rst. Holds in HALT/BREAK.
- Undefined: counter logic is not compiled; insn_cnt_o is tied to 16'h0000; the port list is unchanged.

Test Plan:
- DIV=4. rst, then start_i pulse at edge 10 -> exec_en_o high after edges 14, 18, 22; state_o=1; halted_o=0.
- From HALT, step_i pulse at edge 5 -> state_o=2 and exec_en_o=1 after edge 6; state_o=0, exec_en_o=0 after edge 7; exactly one pulse; a step_i repeated during STEP produces nothing.
- DIV=4, brk_en_i=1, brk_ip_i=4'h3, core ip increments per exec from 0 -> three pulses (ip 0,1,2), then at the fourth wrap state_o=3, no pulse. Then start_i -> next pulse executes ip 3; a later ip 3 in the same run breaks again.
- DIV=4, RUN, stop_i on the same edge as a prescaler wrap -> no exec_en_o, state_o=0. Same with a breakpoint match -> state_o=0, not 3.
- start_i and step_i in the same cycle from HALT -> RUN. rst asserted mid-RUN with prescaler=2 -> all outputs at reset values after that edge; no stray pulse.
- With TD4_RUN_CTRL_INSN_CNT_EN defined, DIV=1, 70000 cycles of RUN -> insn_cnt_o = (pulse count) mod 65536. Undefined -> insn_cnt_o stays 0.
